// File: rtl/sevenseg_pkg.sv
// Shared constants and helpers for the multiplexed seven-segment stopwatch.
package sevenseg_pkg;

    localparam logic [6:0] SEG_BLANK = 7'h7F;

    // Active-low, bit 0 = segment a; entries 0..9 then blank.
    localparam logic [6:0] SEG_PATTERNS [0:10] = '{
        7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
        7'h12, 7'h02, 7'h78, 7'h00, 7'h10,
        SEG_BLANK
    };

    function automatic int unsigned digit_radix(input int unsigned index, input bit time_mode);
        if (time_mode && (index == 3 || index == 5))
            return 6;
        return 10;
    endfunction

    function automatic int unsigned cnt_width(input int unsigned n);
        if (n <= 2)
            return 1;
        return $clog2(n);
    endfunction

endpackage

// File: rtl/bcd_digit_cnt.sv
// Single stopwatch digit: counts 0..RADIX-1 on inc_in, flags its top value.
module bcd_digit_cnt
    import sevenseg_pkg::*;
#(
    parameter int unsigned RADIX = 10
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       clear,
    input  logic       inc_in,
    output logic [3:0] value,
    output logic       at_max
);

    assign at_max = (value == 4'(RADIX - 1));

    always_ff @(posedge clock or negedge reset) begin
        if (!reset)
            value <= '0;
        else if (clear)
            value <= '0;
        else if (inc_in)
            value <= at_max ? '0 : value + 4'd1;
    end

endmodule

// File: rtl/sevenseg_stopwatch.sv
// Parametrised stopwatch with lap hold, leading-zero blanking and a
// multiplexed common-anode seven-segment driver.
module sevenseg_stopwatch
    import sevenseg_pkg::*;
#(
    parameter int unsigned CLK_FREQ_HZ   = 100_000_000,
    parameter int unsigned TICK_HZ       = 100,
    parameter int unsigned SCAN_CYCLES   = 100_000,
    parameter int unsigned NUM_DIGITS    = 8,
    parameter int unsigned TIME_MODE     = 1,
    parameter int unsigned BLANK_LEADING = 0
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  enable,
    input  logic                  clear,
    input  logic                  lap,
    output logic [NUM_DIGITS-1:0] anode_assert,
    output logic [6:0]            segs,
    output logic                  dp,
    output logic                  overflow
);

    localparam int unsigned DIV    = CLK_FREQ_HZ / TICK_HZ;
    localparam int unsigned PRE_W  = cnt_width(DIV);
    localparam int unsigned SCAN_W = cnt_width(SCAN_CYCLES);
    localparam int unsigned IDX_W  = cnt_width(NUM_DIGITS);

    logic [PRE_W-1:0]                 pre_cnt;
    logic                             tick;
    logic [NUM_DIGITS-1:0]            at_max;
    logic [NUM_DIGITS-1:0]            inc;
    logic                             carry;
    logic                             wrap;
    logic [NUM_DIGITS-1:0][3:0]       live;
    logic [NUM_DIGITS-1:0][3:0]       snap;
    logic [NUM_DIGITS-1:0][3:0]       disp;
    logic                             hold;
    logic [NUM_DIGITS-1:0]            blank;
    logic                             zero_above;
    logic [SCAN_W-1:0]                scan_cnt;
    logic [IDX_W-1:0]                 scan_idx;
    logic [31:0]                      idx32;
    logic [3:0]                       cur_val;
    logic [6:0]                       seg_next;
    logic                             dp_next;
    logic [NUM_DIGITS-1:0]            anode_next;

    // Prescaler freezes while paused so a partial tick is kept.
    assign tick = enable && (pre_cnt == PRE_W'(DIV - 1));

    always_ff @(posedge clock or negedge reset) begin
        if (!reset)
            pre_cnt <= '0;
        else if (clear)
            pre_cnt <= '0;
        else if (enable)
            pre_cnt <= tick ? '0 : pre_cnt + PRE_W'(1);
    end

    // Ripple enable: digit i steps when tick and every lower digit is at max.
    always_comb begin
        inc   = '0;
        carry = tick;
        for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
            inc[i] = carry;
            carry  = carry & at_max[i];
        end
        wrap = carry;
    end

    for (genvar g = 0; g < NUM_DIGITS; g++) begin : g_digit
        bcd_digit_cnt #(
            .RADIX(digit_radix(g, TIME_MODE != 0))
        ) u_cnt (
            .clock  (clock),
            .reset  (reset),
            .clear  (clear),
            .inc_in (inc[g]),
            .value  (live[g]),
            .at_max (at_max[g])
        );
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset)
            overflow <= 1'b0;
        else
            overflow <= wrap & ~clear;
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            hold <= 1'b0;
            snap <= '0;
        end else if (clear) begin
            hold <= 1'b0;
        end else if (lap) begin
            if (!hold)
                snap <= live;
            hold <= ~hold;
        end
    end

    assign disp = hold ? snap : live;

    // Walk from the top digit down; blanking stops at the first non-zero digit.
    always_comb begin
        blank      = '0;
        zero_above = 1'b1;
        for (int unsigned k = 0; k < NUM_DIGITS; k++) begin
            zero_above = zero_above && (disp[NUM_DIGITS-1-k] == 4'd0);
            if (BLANK_LEADING != 0 && (NUM_DIGITS - 1 - k) > 2)
                blank[NUM_DIGITS-1-k] = zero_above;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            scan_cnt <= '0;
            scan_idx <= '0;
        end else if (scan_cnt == SCAN_W'(SCAN_CYCLES - 1)) begin
            scan_cnt <= '0;
            scan_idx <= (scan_idx == IDX_W'(NUM_DIGITS - 1)) ? '0 : scan_idx + IDX_W'(1);
        end else begin
            scan_cnt <= scan_cnt + SCAN_W'(1);
        end
    end

    always_comb begin
        idx32   = 32'(scan_idx);
        cur_val = disp[scan_idx];
        if (blank[scan_idx] || cur_val > 4'd9)
            seg_next = SEG_BLANK;
        else
            seg_next = SEG_PATTERNS[cur_val];
        dp_next    = !((idx32 == 2) || (TIME_MODE != 0 && (idx32 == 4 || idx32 == 6)));
        anode_next = ~(NUM_DIGITS'(1) << scan_idx);
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            anode_assert <= '1;
            segs         <= SEG_BLANK;
            dp           <= 1'b1;
        end else begin
            anode_assert <= anode_next;
            segs         <= seg_next;
            dp           <= dp_next;
        end
    end

endmodule

// File: tb/tb_sevenseg_stopwatch.sv
// Self-checking bench: an 8-digit hh:mm:ss.cc instance and a 4-digit
// blanking instance, read back by decoding one full display scan.
`timescale 1ns/1ps
module tb_sevenseg_stopwatch;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n;
    logic       en_a, clr_a, lap_a;
    logic       en_b, clr_b, lap_b;
    logic [7:0] an_a;
    logic [6:0] segs_a;
    logic       dp_a, ovf_a;
    logic [3:0] an_b;
    logic [6:0] segs_b;
    logic       dp_b, ovf_b;

    sevenseg_stopwatch #(
        .CLK_FREQ_HZ(1000), .TICK_HZ(100), .SCAN_CYCLES(4),
        .NUM_DIGITS(8), .TIME_MODE(1), .BLANK_LEADING(0)
    ) dut_a (
        .clock(clk), .reset(rst_n), .enable(en_a), .clear(clr_a), .lap(lap_a),
        .anode_assert(an_a), .segs(segs_a), .dp(dp_a), .overflow(ovf_a)
    );

    sevenseg_stopwatch #(
        .CLK_FREQ_HZ(200), .TICK_HZ(100), .SCAN_CYCLES(4),
        .NUM_DIGITS(4), .TIME_MODE(1), .BLANK_LEADING(1)
    ) dut_b (
        .clock(clk), .reset(rst_n), .enable(en_b), .clear(clr_b), .lap(lap_b),
        .anode_assert(an_b), .segs(segs_b), .dp(dp_b), .overflow(ovf_b)
    );

    int checks   = 0;
    int failures = 0;

    // Reference model state.
    longint ticks_a, ticks_b, snap_a;
    int     pre_a, pre_b;
    bit     hold_a;

    typedef struct packed {
        logic [31:0] dig;
        logic [7:0]  dpn;
    } exp_t;
    exp_t sb[$];

    function automatic exp_t expect_disp(input longint t, input int nd, input bit blank_lead);
        exp_t   e;
        longint v;
        int     r;
        bit     zero;
        v     = t;
        e.dig = '1;
        e.dpn = '1;
        for (int i = 0; i < nd; i++) begin
            r = (i == 3 || i == 5) ? 6 : 10;
            e.dig[4*i +: 4] = 4'(v % r);
            v = v / r;
            e.dpn[i] = !(i == 2 || i == 4 || i == 6);
        end
        if (blank_lead) begin
            zero = 1'b1;
            for (int i = nd - 1; i > 2; i--) begin
                if (zero && e.dig[4*i +: 4] == 4'd0)
                    e.dig[4*i +: 4] = 4'hF;
                else
                    zero = 1'b0;
            end
        end
        return e;
    endfunction

    function automatic logic [3:0] decode(input logic [6:0] s);
        case (s)
            7'h40: return 4'd0;
            7'h79: return 4'd1;
            7'h24: return 4'd2;
            7'h30: return 4'd3;
            7'h19: return 4'd4;
            7'h12: return 4'd5;
            7'h02: return 4'd6;
            7'h78: return 4'd7;
            7'h00: return 4'd8;
            7'h10: return 4'd9;
            7'h7F: return 4'hF;
            default: return 4'hE;
        endcase
    endfunction

    function automatic longint shown_a();
        return hold_a ? snap_a : ticks_a;
    endfunction

    task automatic step_a();
        pre_a++;
        if (pre_a == 10) begin pre_a = 0; ticks_a++; end
    endtask

    task automatic step_b();
        pre_b++;
        if (pre_b == 2) begin pre_b = 0; ticks_b++; end
    endtask

    task automatic run_a(input int n);
        en_a = 1'b1;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            step_a();
        end
        en_a = 1'b0;
    endtask

    task automatic clear_a();
        clr_a = 1'b1;
        @(negedge clk);
        clr_a  = 1'b0;
        ticks_a = 0; pre_a = 0; hold_a = 1'b0;
    endtask

    task automatic pulse_lap_a();
        lap_a = 1'b1;
        @(negedge clk);
        lap_a = 1'b0;
        if (!hold_a) snap_a = ticks_a;
        hold_a = !hold_a;
    endtask

    // Pops one expected display and compares it against a full decoded scan.
    task automatic read_display(input bit sel, input string tag);
        exp_t       e;
        logic [3:0] got [8];
        logic [7:0] gdp;
        logic [7:0] an;
        logic [6:0] sg;
        logic       d;
        int         nd, idx;
        nd = sel ? 4 : 8;
        if (sb.size() == 0) begin
            checks++; failures++;
            $display("FAIL %s: scoreboard empty", tag);
            return;
        end
        e = sb.pop_front();
        for (int i = 0; i < 8; i++) got[i] = 4'hE;
        gdp = '1;
        for (int c = 0; c < nd * 4 + 4; c++) begin
            @(negedge clk);
            an  = sel ? {4'hF, an_b} : an_a;
            sg  = sel ? segs_b : segs_a;
            d   = sel ? dp_b : dp_a;
            idx = -1;
            for (int i = 0; i < nd; i++)
                if (an == ~(8'd1 << i)) idx = i;
            if (idx >= 0) begin
                got[idx] = decode(sg);
                gdp[idx] = d;
            end
        end
        for (int i = 0; i < nd; i++) begin
            checks++;
            if (got[i] !== e.dig[4*i +: 4] || gdp[i] !== e.dpn[i]) begin
                failures++;
                $display("FAIL %s digit%0d: got val=%h dp=%b, want val=%h dp=%b",
                         tag, i, got[i], gdp[i], e.dig[4*i +: 4], e.dpn[i]);
            end
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        en_a = 0; clr_a = 0; lap_a = 0;
        en_b = 0; clr_b = 0; lap_b = 0;
        ticks_a = 0; ticks_b = 0; snap_a = 0; pre_a = 0; pre_b = 0; hold_a = 0;
        repeat (3) @(negedge clk);
        checks++;
        if (an_a !== 8'hFF || segs_a !== 7'h7F || dp_a !== 1'b1 || ovf_a !== 1'b0) begin
            failures++;
            $display("FAIL reset_a: got an=%h segs=%h dp=%b ovf=%b, want FF 7F 1 0",
                     an_a, segs_a, dp_a, ovf_a);
        end
        checks++;
        if (an_b !== 4'hF || segs_b !== 7'h7F || dp_b !== 1'b1 || ovf_b !== 1'b0) begin
            failures++;
            $display("FAIL reset_b: got an=%h segs=%h dp=%b ovf=%b, want F 7F 1 0",
                     an_b, segs_b, dp_b, ovf_b);
        end
        rst_n = 1'b1;
    endtask

    task automatic test_scan();
        logic [7:0] want_an;
        logic       want_dp;
        int         dg;
        for (int j = 1; j <= 64; j++) begin
            @(negedge clk);
            dg      = ((j - 1) / 4) % 8;
            want_an = ~(8'd1 << dg);
            want_dp = !(dg == 2 || dg == 4 || dg == 6);
            checks++;
            if (an_a !== want_an || segs_a !== 7'h40 || dp_a !== want_dp) begin
                failures++;
                $display("FAIL scan cycle %0d: got an=%h segs=%h dp=%b, want an=%h segs=40 dp=%b",
                         j, an_a, segs_a, dp_a, want_an, want_dp);
            end
        end
    endtask

    task automatic test_count();
        run_a(1000);
        sb.push_back(expect_disp(shown_a(), 8, 1'b0));
        read_display(1'b0, "count_1s");
    endtask

    // Also brings dut_b to 59.99 for the overflow test.
    task automatic test_radix();
        clear_a();
        en_a = 1'b1;
        for (int i = 0; i < 59990; i++) begin
            en_b = (i < 11998);
            @(negedge clk);
            step_a();
            if (i < 11998) step_b();
        end
        en_a = 1'b0;
        en_b = 1'b0;
        sb.push_back(expect_disp(shown_a(), 8, 1'b0));
        read_display(1'b0, "radix_59_99");
        run_a(10);
        sb.push_back(expect_disp(shown_a(), 8, 1'b0));
        read_display(1'b0, "radix_1_00_00");
    endtask

    task automatic test_pause();
        run_a(5);
        repeat (50) @(negedge clk);
        run_a(4);
        sb.push_back(expect_disp(shown_a(), 8, 1'b0));
        read_display(1'b0, "pause_no_tick");
        run_a(1);
        sb.push_back(expect_disp(shown_a(), 8, 1'b0));
        read_display(1'b0, "pause_tick");
    endtask

    task automatic test_lap();
        clear_a();
        run_a(420);
        pulse_lap_a();
        run_a(300);
        sb.push_back(expect_disp(shown_a(), 8, 1'b0));
        read_display(1'b0, "lap_hold_42");
        pulse_lap_a();
        sb.push_back(expect_disp(shown_a(), 8, 1'b0));
        read_display(1'b0, "lap_release_72");
    endtask

    task automatic test_clear_priority();
        run_a(25);
        pulse_lap_a();
        run_a(14);
        // Prescaler at its last count: this edge would tick without clear.
        clr_a = 1'b1;
        en_a  = 1'b1;
        @(negedge clk);
        clr_a = 1'b0;
        en_a  = 1'b0;
        ticks_a = 0; pre_a = 0; hold_a = 1'b0;
        sb.push_back(expect_disp(shown_a(), 8, 1'b0));
        read_display(1'b0, "clear_vs_tick");
        run_a(5);
        clr_a = 1'b1;
        lap_a = 1'b1;
        @(negedge clk);
        clr_a = 1'b0;
        lap_a = 1'b0;
        ticks_a = 0; pre_a = 0; hold_a = 1'b0;
        run_a(9);
        sb.push_back(expect_disp(shown_a(), 8, 1'b0));
        read_display(1'b0, "clear_prescaler");
        run_a(1);
        sb.push_back(expect_disp(shown_a(), 8, 1'b0));
        read_display(1'b0, "clear_vs_lap");
    endtask

    task automatic test_overflow();
        int pulses, pos;
        sb.push_back(expect_disp(ticks_b, 4, 1'b1));
        read_display(1'b1, "ovf_pre_59_99");
        pulses = 0;
        pos    = 0;
        for (int s = 1; s <= 6; s++) begin
            en_b = (s <= 2);
            @(negedge clk);
            if (s <= 2) step_b();
            if (ovf_b === 1'b1) begin pulses++; pos = s; end
        end
        en_b = 1'b0;
        checks++;
        if (pulses != 1 || pos != 2) begin
            failures++;
            $display("FAIL overflow_pulse: got pulses=%0d at=%0d, want pulses=1 at=2", pulses, pos);
        end
        sb.push_back(expect_disp(ticks_b, 4, 1'b1));
        read_display(1'b1, "ovf_wrap_blank");
    endtask

    task automatic test_async_reset();
        run_a(37);
        en_a = 1'b1;
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if (an_a !== 8'hFF || segs_a !== 7'h7F || dp_a !== 1'b1 || ovf_a !== 1'b0) begin
            failures++;
            $display("FAIL async_reset: got an=%h segs=%h dp=%b ovf=%b, want FF 7F 1 0",
                     an_a, segs_a, dp_a, ovf_a);
        end
        en_a = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        ticks_a = 0; pre_a = 0; hold_a = 1'b0;
        sb.push_back(expect_disp(shown_a(), 8, 1'b0));
        read_display(1'b0, "after_async_reset");
    endtask

    initial begin
        #5ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_scan();
        test_count();
        test_radix();
        test_pause();
        test_lap();
        test_clear_priority();
        test_overflow();
        test_async_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
